// File: rtl/memory_arbiter_if.sv
// Bus bundle for memory_arbiter: fetch port, data port and RAM port.
// slave = arbiter view, master = CPU/RAM environment view.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;

  modport slave (
    input  iREN, iaddr,
    input  dREN, dWEN, daddr, dstore,
    input  ramload, ramready,
    output iload, iwait, dload, dwait,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr,
    output dREN, dWEN, daddr, dstore,
    output ramload, ramready,
    input  iload, iwait, dload, dwait,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Ports: CLK, RST (sync, active-high), bus (memory_arbiter_if.slave).
module memory_arbiter #(
  parameter int MAX_DSTREAK = 4
) (
  input logic              CLK,
  input logic              RST,
  memory_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_D = 2'd1;
  localparam logic [1:0] BUSY_I = 2'd2;
  localparam logic [3:0] MAXS   = 4'(MAX_DSTREAK);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wr_q, wr_d;
  logic [3:0]  streak_q, streak_d;

  logic dreq;
  logic busy_d;
  logic busy_i;
  logic give_i;
  logic d_done;
  logic i_done;

  assign dreq = bus.dREN | bus.dWEN;

  // Reset masks the busy states so the RAM port
  // goes quiet in the reset cycle itself.
  assign busy_d = ~RST & (state_q == BUSY_D);
  assign busy_i = ~RST & (state_q == BUSY_I);

  // Fetch wins only when data is absent or the
  // data streak has used up its allowance.
  assign give_i = bus.iREN
                & (~dreq | (streak_q == MAXS));

  assign bus.ramWEN   = busy_d & wr_q;
  assign bus.ramREN   = busy_i | (busy_d & ~wr_q);
  assign bus.ramaddr  = (busy_d | busy_i) ? addr_q : '0;
  assign bus.ramstore = (busy_d | busy_i) ? store_q : '0;

  // A requester that dropped its request mid-access
  // gets neither a completion nor data.
  assign d_done = busy_d & bus.ramready & dreq;
  assign i_done = busy_i & bus.ramready & bus.iREN;

  assign bus.dwait = dreq & ~d_done;
  assign bus.iwait = bus.iREN & ~i_done;
  assign bus.dload = d_done ? bus.ramload : '0;
  assign bus.iload = i_done ? bus.ramload : '0;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (give_i) begin
          state_d  = BUSY_I;
          addr_d   = bus.iaddr;
          store_d  = '0;
          wr_d     = 1'b0;
          streak_d = '0;
        end else if (dreq) begin
          state_d = BUSY_D;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          // read+write together is a plain write
          wr_d    = bus.dWEN;
          if (!bus.iREN) begin
            streak_d = '0;
          end else if (streak_q != MAXS) begin
            streak_d = streak_q + 4'd1;
          end
        end
      end
      BUSY_D, BUSY_I: begin
        if (bus.ramready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      streak_q <= streak_d;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed cases plus random
// clients, a latency-randomized RAM and a transaction-level model.
module tb_memory_arbiter;
  localparam int MAXD = 4;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ram_t;

  typedef struct packed {
    logic        is_i;
    logic [31:0] data;
  } cmp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  memory_arbiter_if bus();

  memory_arbiter #(.MAX_DSTREAK(MAXD)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int errs = 0;
  int dcnt = 0;
  int icnt = 0;
  int ram_lat = -1;

  ram_t rq[$];
  cmp_t cq[$];

  logic [31:0] m_mem[logic [31:0]];
  logic [31:0] r_mem[logic [31:0]];

  logic        m_busy = 1'b0;
  logic        m_is_i = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_store = '0;
  int          m_streak = 0;

  function automatic logic [31:0] init_val(logic [31:0] a);
    return a ^ 32'hA5C3_0000 ^ {a[15:0], 16'h0};
  endfunction

  function automatic logic [31:0] m_rd(logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] r_rd(logic [31:0] a);
    return r_mem.exists(a) ? r_mem[a] : init_val(a);
  endfunction

  task automatic chk(string nm, logic [65:0] act,
                     logic [65:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic miss(string nm);
    vecs++;
    errs++;
    $display("FAIL %s: got event, want none at %0t",
             nm, $time);
  endtask

  // Transaction-level model: one access at a time, data first
  // unless a waiting fetch has seen MAXD data grants in a row.
  initial begin
    logic dq;
    ram_t r;
    cmp_t c;
    forever begin
      @(negedge CLK);
      dq = bus.dREN | bus.dWEN;
      if (RST) begin
        m_busy = 1'b0;
        m_streak = 0;
      end else if (m_busy) begin
        if (bus.ramready) begin
          m_busy = 1'b0;
          if (m_is_i) begin
            if (bus.iREN) begin
              c.is_i = 1'b1;
              c.data = m_rd(m_addr);
              cq.push_back(c);
            end
          end else begin
            c.is_i = 1'b0;
            c.data = m_we ? 32'h0 : m_rd(m_addr);
            if (m_we) m_mem[m_addr] = m_store;
            if (dq) cq.push_back(c);
          end
        end
      end else if (dq && !(bus.iREN && m_streak == MAXD)) begin
        m_busy = 1'b1;
        m_is_i = 1'b0;
        m_we = bus.dWEN;
        m_addr = bus.daddr;
        m_store = bus.dstore;
        r.re = ~bus.dWEN;
        r.we = bus.dWEN;
        r.addr = bus.daddr;
        r.data = bus.dstore;
        rq.push_back(r);
        if (!bus.iREN) m_streak = 0;
        else if (m_streak < MAXD) m_streak++;
      end else if (bus.iREN) begin
        m_busy = 1'b1;
        m_is_i = 1'b1;
        m_we = 1'b0;
        m_addr = bus.iaddr;
        r.re = 1'b1;
        r.we = 1'b0;
        r.addr = bus.iaddr;
        r.data = 32'h0;
        rq.push_back(r);
        m_streak = 0;
      end
    end
  end

  // RAM: fixed or random latency; an access cut off by reset
  // gets a stray ready pulse one cycle later.
  initial begin
    bit active;
    bit stray;
    int cnt;
    active = 0;
    stray = 0;
    cnt = 0;
    bus.ramready = 1'b0;
    bus.ramload = '0;
    forever begin
      @(posedge CLK);
      #2;
      bus.ramready = 1'b0;
      bus.ramload = '0;
      if (RST) begin
        stray = active;
        active = 0;
      end else if (stray) begin
        bus.ramready = 1'b1;
        bus.ramload = $urandom;
        stray = 0;
      end else if (bus.ramREN | bus.ramWEN) begin
        if (!active) begin
          active = 1;
          cnt = (ram_lat < 0) ? $urandom_range(0, 3) : ram_lat;
        end
        if (cnt == 0) begin
          bus.ramready = 1'b1;
          active = 0;
          if (bus.ramWEN) r_mem[bus.ramaddr] = bus.ramstore;
          else bus.ramload = r_rd(bus.ramaddr);
        end else begin
          cnt--;
        end
      end else begin
        active = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT shows an
  // access start or a completion.
  logic prev_en = 1'b0;
  logic prev_rdy = 1'b0;
  logic prev_rst = 1'b0;

  initial begin
    logic en;
    logic dq;
    ram_t cur;
    ram_t act;
    cmp_t c;
    cur = '0;
    forever begin
      @(negedge CLK);
      #2;
      en = bus.ramREN | bus.ramWEN;
      act.re = bus.ramREN;
      act.we = bus.ramWEN;
      act.addr = bus.ramaddr;
      act.data = bus.ramstore;
      if (RST || prev_rst) chk("rst_ram", act, '0);
      if (en && (!prev_en || prev_rdy)) begin
        if (rq.size() == 0) miss("ram_unexpected");
        else begin
          cur = rq.pop_front();
          chk("ram_start", act, cur);
        end
      end else if (en) begin
        chk("ram_hold", act, cur);
      end
      dq = bus.dREN | bus.dWEN;
      if (dq && !bus.dwait) begin
        dcnt++;
        if (cq.size() == 0) miss("d_unexpected");
        else begin
          c = cq.pop_front();
          chk("d_done", {1'b0, bus.dload}, c);
        end
      end else begin
        chk("d_wait", {bus.dwait, bus.dload}, {dq, 32'h0});
      end
      if (bus.iREN && !bus.iwait) begin
        icnt++;
        if (cq.size() == 0) miss("i_unexpected");
        else begin
          c = cq.pop_front();
          chk("i_done", {1'b1, bus.iload}, c);
        end
      end else begin
        chk("i_wait", {bus.iwait, bus.iload},
            {bus.iREN, 32'h0});
      end
      prev_en = en;
      prev_rdy = bus.ramready;
      prev_rst = RST;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_d(string nm);
    int c0;
    int n;
    c0 = dcnt;
    n = 0;
    while (dcnt == c0 && n < 50) begin
      cyc();
      n++;
    end
    if (dcnt == c0) begin
      vecs++;
      errs++;
      $display("FAIL %s: got no data completion, want one", nm);
    end
  endtask

  task automatic wait_i(string nm);
    int c0;
    int n;
    c0 = icnt;
    n = 0;
    while (icnt == c0 && n < 50) begin
      cyc();
      n++;
    end
    if (icnt == c0) begin
      vecs++;
      errs++;
      $display("FAIL %s: got no fetch completion, want one", nm);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  task automatic new_d();
    int op;
    op = $urandom_range(0, 2);
    bus.dREN = (op != 1);
    bus.dWEN = (op != 0);
    bus.daddr = rnd_addr();
    bus.dstore = $urandom;
  endtask

  initial begin
    bit dact;
    bit iact;
    int dseen;
    int iseen;
    int p;
    bus.iREN = 1'b0;
    bus.iaddr = '0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    bus.daddr = '0;
    bus.dstore = '0;
    RST = 1'b1;
    repeat (3) cyc();
    RST = 1'b0;

    // plain read, latency 2
    m_mem[32'h100] = 32'hDEADBEEF;
    r_mem[32'h100] = 32'hDEADBEEF;
    ram_lat = 2;
    bus.dREN = 1'b1;
    bus.daddr = 32'h100;
    wait_d("read_100");
    bus.dREN = 1'b0;
    cyc();

    // write and fetch collide; write goes first
    ram_lat = 1;
    bus.iREN = 1'b1;
    bus.iaddr = 32'h200;
    bus.dWEN = 1'b1;
    bus.daddr = 32'h40;
    bus.dstore = 32'h1234;
    wait_d("conflict_wr");
    bus.dWEN = 1'b0;
    wait_i("conflict_fetch");
    bus.iREN = 1'b0;
    cyc();

    // read+write together, then read back the earlier write
    bus.dREN = 1'b1;
    bus.dWEN = 1'b1;
    bus.daddr = 32'h8;
    bus.dstore = 32'h55;
    wait_d("both_rw");
    bus.dWEN = 1'b0;
    bus.daddr = 32'h40;
    wait_d("readback_40");
    bus.dREN = 1'b0;
    cyc();

    // address moves after the grant
    ram_lat = 3;
    bus.dREN = 1'b1;
    bus.daddr = 32'h10;
    cyc();
    cyc();
    bus.daddr = 32'h20;
    wait_d("addr_change");
    bus.dREN = 1'b0;
    cyc();

    // reset mid-write with the request still held
    ram_lat = 6;
    bus.dWEN = 1'b1;
    bus.daddr = 32'h30;
    bus.dstore = 32'hCAFE;
    repeat (3) cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    wait_d("after_reset");
    bus.dWEN = 1'b0;
    cyc();
    ram_lat = -1;

    // random clients; early part keeps both saturated
    dact = 0;
    iact = 0;
    dseen = 0;
    iseen = 0;
    for (int n = 0; n < 4000; n++) begin
      p = (n < 400) ? 100 : 65;
      RST = ($urandom_range(0, 599) == 0);
      if (!dact) begin
        if (!(m_busy && !m_is_i) &&
            $urandom_range(0, 99) < p) begin
          new_d();
          dact = 1;
          dseen = dcnt;
        end
      end else if (dcnt != dseen) begin
        if ($urandom_range(0, 1) == 1) begin
          new_d();
          dseen = dcnt;
        end else begin
          bus.dREN = 1'b0;
          bus.dWEN = 1'b0;
          dact = 0;
        end
      end else begin
        if ($urandom_range(0, 19) == 0) begin
          bus.daddr = rnd_addr();
          bus.dstore = $urandom;
        end
        if ($urandom_range(0, 99) == 0) begin
          bus.dREN = 1'b0;
          bus.dWEN = 1'b0;
          dact = 0;
        end
      end
      if (!iact) begin
        if (!(m_busy && m_is_i) &&
            $urandom_range(0, 99) < p) begin
          bus.iREN = 1'b1;
          bus.iaddr = rnd_addr();
          iact = 1;
          iseen = icnt;
        end
      end else if (icnt != iseen) begin
        if ($urandom_range(0, 1) == 1) begin
          bus.iaddr = rnd_addr();
          iseen = icnt;
        end else begin
          bus.iREN = 1'b0;
          iact = 0;
        end
      end else begin
        if ($urandom_range(0, 19) == 0) bus.iaddr = rnd_addr();
        if ($urandom_range(0, 99) == 0) begin
          bus.iREN = 1'b0;
          iact = 0;
        end
      end
      cyc();
    end

    RST = 1'b0;
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    repeat (20) cyc();
    chk("ram_q_left", 66'(rq.size()), 66'd0);
    chk("cmp_q_left", 66'(cq.size()), 66'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter MAX_DSTREAK, default 4: consecutive data grants allowed while a fetch waits (legal 1..15).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 iREN  in  1  instruction fetch request.
REQ-005 iaddr  in  32  fetch word address.
REQ-006 iload  out  32  fetch data; valid while iwait=0.
REQ-007 iwait  out  1  fetch stall; 0 marks fetch completion.
REQ-008 dREN  in  1  data read request.
REQ-009 dWEN  in  1  data write request.
REQ-010 daddr  in  32  data word address.
REQ-011 dstore  in  32  write data.
REQ-012 dload  out  32  read data; valid while dwait=0.
REQ-013 dwait  out  1  data stall; 0 marks data completion.
REQ-014 ramREN  out  1  RAM read enable.
REQ-015 ramWEN  out  1  RAM write enable.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data.
REQ-019 ramready  in  1  RAM access done, one-cycle pulse, variable latency >=0 cycles after enable.

Function
REQ-020 States: IDLE, BUSY_D, BUSY_I; one RAM access outstanding at most.
REQ-021 IDLE: ramREN=ramWEN=0; iwait=iREN; dwait=dREN|dWEN.
REQ-022 IDLE grant: data pending (dREN|dWEN) beats iREN, except when dstreak==MAX_DSTREAK and iREN=1, then fetch granted.
REQ-023 On grant edge: latch address, dstore and op (read/write) into registers; go BUSY_D or BUSY_I.
REQ-024 dREN=dWEN=1 simultaneously: treated as write; no read performed.
REQ-025 BUSY_x: ram outputs driven only from latched registers; input address/data changes ignored.
REQ-026 BUSY_D: ramWEN=latched write, ramREN=latched read; BUSY_I: ramREN=1, ramWEN=0.
REQ-027 Completion: in BUSY_D with ramready=1, dwait=0 and dload=ramload same cycle; BUSY_I likewise iwait=0, iload=ramload.
REQ-028 Non-completing requester's wait equals its request level; ramready outside BUSY ignored.
REQ-029 After completion edge, state returns to IDLE; min request-to-completion latency 1 cycle (grant edge then ramready same cycle).
REQ-030 Requester dropping request mid-access: access still completes at RAM; wait/data for it not signalled, no retry.
REQ-031 dstreak (4-bit): +1 on data grant with iREN=1; cleared on fetch grant or data grant with iREN=0; saturates at MAX_DSTREAK.
REQ-032 iload/dload = 0 whenever not completing.

Reset
REQ-033 RST=1 at edge: state IDLE, dstreak 0, latched regs 0, regardless of state, including mid-access.
REQ-034 During and one cycle after reset edge: ramREN=ramWEN=0, ramaddr=ramstore=0; waits follow REQ-021.
REQ-035 Access aborted by reset not reissued; ramready arriving after reset ignored.

Verification
REQ-036 Read: dREN=1, daddr=0x100; ramready 2 cycles after ramREN, ramload=0xDEADBEEF -> dload=0xDEADBEEF, dwait low exactly 1 cycle, state IDLE next.
REQ-037 Conflict: iREN=dWEN=1 same cycle, daddr=0x40, dstore=0x1234 -> write 0x1234@0x40 first, then fetch of iaddr; iwait high until fetch ramready.
REQ-038 Starvation: iREN held, data requests back-to-back, MAX_DSTREAK=4 -> 4 data grants, 5th grant is fetch, dstreak then 0.
REQ-039 Address change: daddr 0x10 -> 0x20 one cycle after grant -> ramaddr stays 0x10 until completion.
REQ-040 Reset mid-access: RST in BUSY_D before ramready -> next cycle ramREN=ramWEN=0, IDLE; late ramready produces no completion.
REQ-041 Both dREN=dWEN=1, daddr=0x8 -> ramWEN=1, ramREN=0 for the access.
